// File: rtl/pc_sequencer.sv
// Stage-1 fetch controller: boot hold, stall/redirect/flush sequencing for the PC and
// stage-1/2 instruction register, plus stalled-cycle and redirect performance counters.
//
// state | meaning
// BOOT  | post-reset hold, PC stalled and stage 1 flushed for BOOT_CYCLES cycles
// RUN   | normal fetch
// STALL | a cache is holding the pipeline; pending redirect kept via stable br_taken
// FLUSH | wrong-path word from the sync-read icache arrives; turn it into a bubble
module pc_sequencer #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             br_taken,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             pc_sel,
    output logic             flush,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] boot_cnt;
    logic          stall;

    assign stall     = icache_stall | dcache_stall;
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        pc_stall  = 1'b0;
        pc_sel    = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_stall = 1'b1;
                flush    = 1'b1;
                if (boot_cnt == '0)
                    state_nxt = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                pc_stall = stall;
                pc_sel   = br_taken;
                flush    = br_taken & ~stall;
                if (stall)
                    state_nxt = ST_STALL;
                else if (br_taken)
                    state_nxt = ST_FLUSH;
                else
                    state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                // stage 2 holds a bubble here, so br_taken is not a real redirect
                pc_stall = stall;
                flush    = 1'b1;
                state_nxt = stall ? ST_FLUSH : ST_RUN;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_BOOT;
            boot_cnt <= BOOT_INIT;
        end else begin
            state <= state_nxt;
            if (state == ST_BOOT && boot_cnt != '0)
                boot_cnt <= boot_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (pc_stall && state != ST_BOOT)
                stall_cnt <= stall_cnt + 1'b1;
            if (pc_sel && !pc_stall)
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; inputs change on the falling edge and
// outputs are sampled 1 ns later, so Mealy outputs are checked within the same cycle.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        icache_stall;
    logic        dcache_stall;
    logic        br_taken;
    logic        cnt_clr;
    logic        pc_stall;
    logic        pc_sel;
    logic        flush;
    logic [1:0]  fsm_state;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    pc_sequencer #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .br_taken     (br_taken),
        .cnt_clr      (cnt_clr),
        .pc_stall     (pc_stall),
        .pc_sel       (pc_sel),
        .flush        (flush),
        .fsm_state    (fsm_state),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {pc_stall, pc_sel, flush, fsm_state}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_stall, pc_sel, flush, fsm_state}, {27'd0, exp});
    endtask

    // advance one clock, then apply new inputs on the falling edge and let them settle
    task automatic cyc(input logic ic, input logic dc, input logic br, input logic clr);
        @(posedge clk);
        @(negedge clk);
        icache_stall = ic;
        dcache_stall = dc;
        br_taken     = br;
        cnt_clr      = clr;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        icache_stall = 1'b0;
        dcache_stall = 1'b0;
        br_taken     = 1'b0;
        cnt_clr      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset_out", {1'b1, 1'b0, 1'b1, 2'd0});
        chk("reset_scnt", stall_cnt, 32'd0);
        chk("reset_rcnt", redirect_cnt, 32'd0);
        reset = 1'b0;
        // inputs are ignored during boot
        icache_stall = 1'b1;
        br_taken     = 1'b1;
        #1;
        chk_out("boot1", {1'b1, 1'b0, 1'b1, 2'd0});
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("boot2", {1'b1, 1'b0, 1'b1, 2'd0});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("run_idle", {1'b0, 1'b0, 1'b0, 2'd1});
        chk("boot_scnt", stall_cnt, 32'd0);
        chk("boot_rcnt", redirect_cnt, 32'd0);

        // single redirect
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("br_run", {1'b0, 1'b1, 1'b1, 2'd1});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("br_flush", {1'b0, 1'b0, 1'b1, 2'd3});
        chk("br_rcnt", redirect_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("br_back", {1'b0, 1'b0, 1'b0, 2'd1});

        // clear counters, then icache stall 3 cycles
        cnt_clr = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_rcnt", redirect_cnt, 32'd0);
        chk_out("ist_c1", {1'b1, 1'b0, 1'b0, 2'd1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("ist_c2", {1'b1, 1'b0, 1'b0, 2'd2});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("ist_c3", {1'b1, 1'b0, 1'b0, 2'd2});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("ist_rel", {1'b0, 1'b0, 1'b0, 2'd2});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("ist_run", {1'b0, 1'b0, 1'b0, 2'd1});
        chk("ist_scnt", stall_cnt, 32'd3);
        chk("ist_rcnt", redirect_cnt, 32'd0);

        // redirect held across a dcache stall
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("dsb_c1", {1'b1, 1'b1, 1'b0, 2'd1});
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("dsb_c2", {1'b1, 1'b1, 1'b0, 2'd2});
        chk("dsb_rcnt_hold", redirect_cnt, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("dsb_c3", {1'b0, 1'b1, 1'b1, 2'd2});
        chk("dsb_rcnt_pre", redirect_cnt, 32'd0);

        // FLUSH stretched by icache stall, br_taken ignored
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("dsb_rcnt", redirect_cnt, 32'd1);
        chk_out("fst_c1", {1'b1, 1'b0, 1'b1, 2'd3});
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("fst_c2", {1'b1, 1'b0, 1'b1, 2'd3});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fst_rel", {1'b0, 1'b0, 1'b1, 2'd3});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fst_run", {1'b0, 1'b0, 1'b0, 2'd1});
        chk("fst_scnt", stall_cnt, 32'd7);
        chk("fst_rcnt", redirect_cnt, 32'd1);

        // asynchronous reset mid-STALL
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("pre_rst", {1'b1, 1'b0, 1'b0, 2'd2});
        #1;
        reset = 1'b1;
        #1;
        chk_out("async_rst", {1'b1, 1'b0, 1'b1, 2'd0});
        chk("async_scnt", stall_cnt, 32'd0);
        chk("async_rcnt", redirect_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        icache_stall = 1'b0;
        #1;
        chk_out("rb_boot1", {1'b1, 1'b0, 1'b1, 2'd0});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rb_boot2", {1'b1, 1'b0, 1'b1, 2'd0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("rb_run", {1'b1, 1'b0, 1'b0, 2'd1});

        // cnt_clr wins over a same-cycle increment
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_pre", stall_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_scnt", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
